// File: rtl/branch_predictor.sv
// Gshare branch predictor: a PHT of 2-bit counters indexed by pc XOR speculative history.
// Predictions are recorded in a small FIFO and resolved in order by the branch unit.
// A mispredicted commit restores the speculative history from the architectural history
// and flushes the FIFO.
module branch_predictor #(
  parameter int PATTERN_WIDTH  = 8,
  parameter int INST_MEM_WIDTH = 14,
  parameter int N_B_ENTRY      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fetch_b,
  input  logic [INST_MEM_WIDTH-1:0] pc,
  input  logic [INST_MEM_WIDTH-1:0] target,
  output logic                      fetch_ready,
  output logic                      prediction,
  output logic [PATTERN_WIDTH-1:0]  pattern_out,
  output logic [INST_MEM_WIDTH-1:0] addr_on_failure_out,
  output logic [INST_MEM_WIDTH-1:0] next_pc,
  input  logic                      commit_b,
  input  logic                      commit_failure,
  input  logic [PATTERN_WIDTH-1:0]  commit_pattern
);

  localparam int CNT_W = $clog2(N_B_ENTRY) + 1;
  localparam int PTR_W = (N_B_ENTRY > 1) ? $clog2(N_B_ENTRY) : 1;
  localparam int PHT_N = 2 ** PATTERN_WIDTH;
  localparam logic [CNT_W-1:0]          CNT_FULL = CNT_W'(N_B_ENTRY);
  localparam logic [PTR_W-1:0]          PTR_LAST = PTR_W'(N_B_ENTRY - 1);
  localparam logic [INST_MEM_WIDTH-1:0] PC_STEP  = INST_MEM_WIDTH'(1);

  logic [1:0]               pht [PHT_N];
  logic [PATTERN_WIDTH-1:0] spec_ghr;
  logic [PATTERN_WIDTH-1:0] arch_ghr;
  logic [CNT_W-1:0]         count;
  logic [N_B_ENTRY-1:0]     fifo;
  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;

  logic [PATTERN_WIDTH-1:0]  index;
  logic [INST_MEM_WIDTH-1:0] pc_plus1;
  logic                      accept;
  logic                      commit;
  logic                      actual;
  logic [PATTERN_WIDTH-1:0]  arch_next;

  // Saturating 2-bit counter step toward taken (up=1) or not-taken (up=0).
  function automatic logic [1:0] sat_update(input logic [1:0] c, input logic up);
    if (up) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    else    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  // Circular pointer advance for a depth that need not be a power of two.
  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Lookup, address selection and handshake decode; all read registered state only.
  always_comb begin
    index               = pc[PATTERN_WIDTH-1:0] ^ spec_ghr;
    pattern_out         = index;
    prediction          = pht[index][1];
    pc_plus1            = pc + PC_STEP;
    next_pc             = prediction ? target : pc_plus1;
    addr_on_failure_out = prediction ? pc_plus1 : target;
    fetch_ready         = (count < CNT_FULL) || commit_b;
    accept              = fetch_b && fetch_ready;
    commit              = commit_b && (count != '0);
    actual              = fifo[head] ^ commit_failure;
    arch_next           = {arch_ghr[PATTERN_WIDTH-2:0], actual};
  end

  // Control state: histories, PHT counters, FIFO occupancy and pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spec_ghr <= '0;
      arch_ghr <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
    end else begin
      if (commit) begin
        arch_ghr            <= arch_next;
        pht[commit_pattern] <= sat_update(pht[commit_pattern], actual);
        head                <= inc_ptr(head);
      end
      if (commit && commit_failure) begin
        // Misprediction: resteer history and drop every younger prediction.
        spec_ghr <= arch_next;
        count    <= '0;
        head     <= '0;
        tail     <= '0;
      end else begin
        if (accept) begin
          spec_ghr <= {spec_ghr[PATTERN_WIDTH-2:0], prediction};
          tail     <= inc_ptr(tail);
        end
        case ({accept, commit})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Prediction bit storage; validity is tracked by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept && !(commit && commit_failure)) fifo[tail] <= prediction;
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomised bench for branch_predictor with a behavioural reference
// model and a scoreboard queue of expected values.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_b;
  logic [13:0] pc;
  logic [13:0] target;
  logic        fetch_ready;
  logic        prediction;
  logic [7:0]  pattern_out;
  logic [13:0] addr_on_failure_out;
  logic [13:0] next_pc;
  logic        commit_b;
  logic        commit_failure;
  logic [7:0]  commit_pattern;

  branch_predictor #(.PATTERN_WIDTH(8), .INST_MEM_WIDTH(14), .N_B_ENTRY(4)) dut (
    .clk(clk), .reset(reset), .fetch_b(fetch_b), .pc(pc), .target(target),
    .fetch_ready(fetch_ready), .prediction(prediction), .pattern_out(pattern_out),
    .addr_on_failure_out(addr_on_failure_out), .next_pc(next_pc),
    .commit_b(commit_b), .commit_failure(commit_failure), .commit_pattern(commit_pattern)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   ncmp  = 0;
  int   nfail = 0;

  // Reference model state
  logic [1:0] m_pht [256];
  logic [7:0] m_spec;
  logic [7:0] m_arch;
  logic       m_fifo[$];

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_val(input logic [31:0] obs);
    exp_t e;
    ncmp++;
    if (sb.size() == 0) begin
      nfail++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        nfail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_pht[i] = 2'b01;
    m_spec = 8'h00;
    m_arch = 8'h00;
    m_fifo.delete();
  endtask

  // Push expected combinational outputs for the current inputs, then compare.
  task automatic check_outputs();
    logic [7:0]  idx;
    logic        pr;
    logic [13:0] p1;
    idx = pc[7:0] ^ m_spec;
    pr  = m_pht[idx][1];
    p1  = pc + 14'd1;
    push_exp("prediction", 32'(pr));
    push_exp("pattern_out", 32'(idx));
    push_exp("next_pc", 32'(pr ? target : p1));
    push_exp("addr_on_failure", 32'(pr ? p1 : target));
    push_exp("fetch_ready", 32'((m_fifo.size() < 4) || commit_b));
    check_val(32'(prediction));
    check_val(32'(pattern_out));
    check_val(32'(next_pc));
    check_val(32'(addr_on_failure_out));
    check_val(32'(fetch_ready));
  endtask

  task automatic check_state(input string sfx);
    push_exp({"count", sfx}, 32'(m_fifo.size()));
    push_exp({"spec_ghr", sfx}, 32'(m_spec));
    push_exp({"arch_ghr", sfx}, 32'(m_arch));
    check_val(32'(dut.count));
    check_val(32'(dut.spec_ghr));
    check_val(32'(dut.arch_ghr));
  endtask

  task automatic check_pht(input logic [7:0] i, input string tag);
    push_exp(tag, 32'(m_pht[i]));
    check_val(32'(dut.pht[i]));
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_clock();
    logic [7:0] idx;
    logic       pr, acc, com, p, act;
    idx = pc[7:0] ^ m_spec;
    pr  = m_pht[idx][1];
    acc = fetch_b && ((m_fifo.size() < 4) || commit_b);
    com = commit_b && (m_fifo.size() != 0);
    if (com) begin
      p   = m_fifo.pop_front();
      act = p ^ commit_failure;
      m_arch = {m_arch[6:0], act};
      if (act) m_pht[commit_pattern] = (m_pht[commit_pattern] == 2'd3) ? 2'd3 : m_pht[commit_pattern] + 2'd1;
      else     m_pht[commit_pattern] = (m_pht[commit_pattern] == 2'd0) ? 2'd0 : m_pht[commit_pattern] - 2'd1;
    end
    if (com && commit_failure) begin
      m_spec = m_arch;
      m_fifo.delete();
    end else if (acc) begin
      m_spec = {m_spec[6:0], pr};
      m_fifo.push_back(pr);
    end
  endtask

  task automatic step(input logic f, input logic [13:0] p, input logic [13:0] t,
                      input logic c, input logic cf, input logic [7:0] cp);
    @(negedge clk);
    fetch_b        = f;
    pc             = p;
    target         = t;
    commit_b       = c;
    commit_failure = cf;
    commit_pattern = cp;
    #1;
    check_outputs();
    model_clock();
    @(posedge clk);
    #1;
    check_state("");
  endtask

  // Fetch one branch, then commit it against pattern cp with the requested outcome.
  task automatic train(input logic [7:0] cp, input logic act);
    step(1'b1, 14'($urandom_range(0, 16383)), 14'h0200, 1'b0, 1'b0, 8'h00);
    step(1'b0, 14'h0000, 14'h0000, 1'b1, m_fifo[0] ^ act, cp);
  endtask

  initial begin
    reset = 1'b1;
    fetch_b = 1'b1;
    pc = 14'h3FFF;
    target = 14'h0123;
    commit_b = 1'b0;
    commit_failure = 1'b0;
    commit_pattern = 8'h00;
    model_reset();

    // Outputs while held in reset, including pc+1 wrapping to zero
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check_state("_rst");

    @(negedge clk);
    reset   = 1'b0;
    fetch_b = 1'b0;

    // First fetch after reset: not-taken, history stays zero
    step(1'b1, 14'h0005, 14'h0100, 1'b0, 1'b0, 8'h00);
    // Mispredicted commit: PHT[5] -> 2, both histories -> 1, flush
    step(1'b0, 14'h0000, 14'h0000, 1'b1, 1'b1, 8'h05);
    check_pht(8'h05, "pht05_after_fail");
    // pc 4 XOR history 1 hits PHT[5], now predicted taken
    step(1'b1, 14'h0004, 14'h0100, 1'b0, 1'b0, 8'h00);

    // Fill the queue to four entries
    step(1'b1, 14'h0010, 14'h0020, 1'b0, 1'b0, 8'h00);
    step(1'b1, 14'h0011, 14'h0021, 1'b0, 1'b0, 8'h00);
    step(1'b1, 14'h0012, 14'h0022, 1'b0, 1'b0, 8'h00);
    // Full: fetch ignored
    step(1'b1, 14'h0013, 14'h0023, 1'b0, 1'b0, 8'h00);
    // Full with a correct commit: fetch accepted, count stays four
    step(1'b1, 14'h0014, 14'h0024, 1'b1, 1'b0, 8'h40);
    // Plain commit: down to three
    step(1'b0, 14'h0000, 14'h0000, 1'b1, 1'b0, 8'h41);
    // Mispredict with simultaneous fetch: flush wins
    step(1'b1, 14'h0015, 14'h0025, 1'b1, 1'b1, 8'h42);
    push_exp("spec_eq_arch", 32'(m_arch));
    check_val(32'(dut.spec_ghr));

    // Commit with empty queue is ignored
    step(1'b0, 14'h0000, 14'h0000, 1'b1, 1'b0, 8'h22);
    check_pht(8'h22, "pht22_illegal_commit");

    // Saturation at both ends
    repeat (3) train(8'h10, 1'b1);
    check_pht(8'h10, "pht10_sat_high");
    repeat (2) train(8'h11, 1'b0);
    check_pht(8'h11, "pht11_sat_low");

    // Wrap of pc+1 in normal operation
    step(1'b1, 14'h3FFF, 14'h0777, 1'b0, 1'b0, 8'h00);

    // Randomised traffic against the model
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)));
    end

    // Prepare count=2 with PHT[5]=3, then pulse reset between edges
    for (int k = 0; k < 8 && m_pht[5] != 2'd3; k++) train(8'h05, 1'b1);
    if (m_fifo.size() != 0) step(1'b0, 14'h0000, 14'h0000, 1'b1, 1'b1, 8'h00);
    step(1'b1, 14'h0030, 14'h0031, 1'b0, 1'b0, 8'h00);
    step(1'b1, 14'h0032, 14'h0033, 1'b0, 1'b0, 8'h00);
    check_pht(8'h05, "pht05_before_reset");
    @(negedge clk);
    fetch_b  = 1'b0;
    commit_b = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_state("_async_rst");
    check_pht(8'h05, "pht05_async_rst");
    reset = 1'b0;

    // Normal operation resumes after the pulse
    step(1'b1, 14'h0005, 14'h0100, 1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter PATTERN_WIDTH, default 8, which is both the global history width and the PHT index width.
REQ-002 The block SHALL have parameter INST_MEM_WIDTH, default 14, which is the instruction address width.
REQ-003 The block SHALL have parameter N_B_ENTRY, default 4, which is the in-flight branch queue depth.
REQ-004 Port clk  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-006 Port fetch_b  in  1  SHALL indicate that a conditional branch is being fetched and issued this cycle.
REQ-007 Port pc  in  INST_MEM_WIDTH  SHALL carry the address of the fetched branch.
REQ-008 Port target  in  INST_MEM_WIDTH  SHALL carry the taken-target address of the fetched branch.
REQ-009 Port fetch_ready  out  1  SHALL indicate that the queue can accept fetch_b this cycle.
REQ-010 Port prediction  out  1  SHALL carry the predicted direction (1 = taken).
REQ-011 Port pattern_out  out  PATTERN_WIDTH  SHALL carry the PHT index used for this prediction, passed to the branch unit.
REQ-012 Port addr_on_failure_out  out  INST_MEM_WIDTH  SHALL carry the address of the path not chosen.
REQ-013 Port next_pc  out  INST_MEM_WIDTH  SHALL carry the predicted fetch address.
REQ-014 Port commit_b  in  1  SHALL indicate that the branch unit commits its oldest branch this cycle.
REQ-015 Port commit_failure  in  1  SHALL carry the misprediction flag of the committing branch.
REQ-016 Port commit_pattern  in  PATTERN_WIDTH  SHALL carry the PHT index of the committing branch.

Function
REQ-017 State SHALL consist of a PHT of 2**PATTERN_WIDTH 2-bit saturating counters, spec_ghr, arch_ghr, and a FIFO of N_B_ENTRY prediction bits with count 0..N_B_ENTRY.
REQ-018 The index SHALL be computed as pc[PATTERN_WIDTH-1:0] XOR spec_ghr, and pattern_out SHALL equal this index combinationally.
REQ-019 prediction SHALL equal PHT[index][1] combinationally from registered state, with zero-cycle latency.
REQ-020 When prediction=1, next_pc SHALL be target and addr_on_failure_out SHALL be pc+1; otherwise next_pc SHALL be pc+1 and addr_on_failure_out SHALL be target; the +1 SHALL wrap modulo 2**INST_MEM_WIDTH.
REQ-021 fetch_ready SHALL be 1 when count<N_B_ENTRY or commit_b=1.
REQ-022 A fetch SHALL be accepted when fetch_b=1 and fetch_ready=1; fetch_b=1 while fetch_ready=0 SHALL be ignored with no state change.
REQ-023 An accepted fetch SHALL set spec_ghr to {spec_ghr[PATTERN_WIDTH-2:0], prediction} and push prediction into the FIFO tail.
REQ-024 On a commit (commit_b=1, count!=0), the block SHALL pop the FIFO head p, compute actual = p XOR commit_failure, and set arch_ghr to {arch_ghr[PATTERN_WIDTH-2:0], actual}.
REQ-025 On a commit, PHT[commit_pattern] SHALL increment (saturating at 3) if actual=1 and decrement (saturating at 0) otherwise.
REQ-026 A PHT write SHALL become visible the next cycle; a same-cycle read of the same index SHALL return the old value.
REQ-027 A commit with commit_failure=1 SHALL set spec_ghr to the new arch_ghr value and count to 0, discarding any same-cycle accepted fetch.
REQ-028 A commit with commit_failure=0 and a same-cycle accepted fetch SHALL leave count unchanged and SHALL apply both GHR updates.
REQ-029 commit_b=1 while count=0 SHALL be illegal and ignored; state SHALL be unchanged.
REQ-030 Count arithmetic SHALL be performed at $clog2(N_B_ENTRY)+1 bits and SHALL never exceed N_B_ENTRY.

Reset
REQ-031 Asserting reset at any time, including mid-operation, SHALL immediately set every PHT counter to 2'b01, spec_ghr=0, arch_ghr=0, and count=0.
REQ-032 With reset asserted: fetch_ready=1; prediction=0; pattern_out=pc[PATTERN_WIDTH-1:0]; next_pc=pc+1; addr_on_failure_out=target.

Verification
REQ-033 Reset, then pc=0x005, target=0x100, fetch_b=1 -> prediction=0, pattern_out=0x05, next_pc=0x006, addr_on_failure_out=0x100; next cycle spec_ghr=0x00, count=1.
REQ-034 From REQ-033, commit_b=1, commit_failure=1, commit_pattern=0x05 -> PHT[0x05]=2, arch_ghr=0x01, spec_ghr=0x01, count=0; next fetch at pc=0x004 -> pattern_out=0x05, prediction=1, next_pc=0x100.
REQ-035 Four fetches with no commit -> count=4, fetch_ready=0; fifth fetch_b ignored; fifth fetch_b with commit_b=1, failure=0 -> accepted, count stays 4.
REQ-036 count=3, commit_b=1 with commit_failure=1 and fetch_b=1 in the same cycle -> count=0, spec_ghr==arch_ghr, fetch discarded.
REQ-037 Saturation: PHT[0x10]=3 plus taken commit -> stays 3; PHT[0x11]=0 plus not-taken commit -> stays 0.
REQ-038 Async reset pulse between clock edges while count=2 and PHT[0x05]=3 -> count=0, PHT[0x05]=1, spec_ghr=0, without waiting for a clock edge.
